// File: rtl/spi_slave_fifo.sv
// SPI slave sampled in the system clock domain: pad synchronisers, CPOL/CPHA edge
// selection, full-duplex shift registers and an RX FIFO with a valid/ready read port.
`timescale 1ns/1ps
module spi_slave_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               SS,
    input  logic                               SCLK,
    input  logic                               MOSI,
    output logic                               MISO,
    output logic                               miso_oe,
    output logic [DATA_WIDTH-1:0]              rx_data,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_count,
    input  logic [DATA_WIDTH-1:0]              tx_data,
    output logic                               tx_ack,
    output logic                               overflow,
    input  logic                               ovf_clr,
    output logic                               frame_err
);

    localparam int CNT_W   = $clog2(DATA_WIDTH);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = $clog2(FIFO_DEPTH+1);
    localparam logic [2:0] SYNC_IDLE = {1'b1, (CPOL != 0), 1'b0};

    // Bit order in the synchroniser vectors: {SS, SCLK, MOSI}
    logic [2:0] sync1_reg, sync2_reg;
    logic [1:0] sync3_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= SYNC_IDLE;
            sync2_reg <= SYNC_IDLE;
            sync3_reg <= SYNC_IDLE[2:1];
        end else begin
            sync1_reg <= {SS, SCLK, MOSI};
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg[2:1];
        end
    end

    logic ss_now, ss_prev, sclk_now, sclk_prev, mosi_now;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge;

    assign ss_now      = sync2_reg[2];
    assign sclk_now    = sync2_reg[1];
    assign mosi_now    = sync2_reg[0];
    assign ss_prev     = sync3_reg[1];
    assign sclk_prev   = sync3_reg[0];
    assign ss_fall     = ss_prev & ~ss_now;
    assign ss_rise     = ~ss_prev & ss_now;
    assign sclk_rise   = sclk_now & ~sclk_prev;
    assign sclk_fall   = ~sclk_now & sclk_prev;
    assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
    assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

    logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] rx_shift_reg, rx_shift_next;
    logic [DATA_WIDTH-1:0] tx_shift_reg, tx_shift_next;
    logic [DATA_WIDTH-1:0] push_data_reg, push_data_next;
    logic                  first_reg, first_next;
    logic                  load_pend_reg, load_pend_next;
    logic                  push_reg, push_next;
    logic                  tx_ack_reg, tx_ack_next;
    logic                  frame_err_reg, frame_err_next;

    always_comb begin
        bit_cnt_next   = bit_cnt_reg;
        rx_shift_next  = rx_shift_reg;
        tx_shift_next  = tx_shift_reg;
        push_data_next = push_data_reg;
        first_next     = first_reg;
        load_pend_next = load_pend_reg;
        push_next      = 1'b0;
        tx_ack_next    = 1'b0;
        frame_err_next = 1'b0;
        if (ss_fall) begin
            bit_cnt_next   = '0;
            tx_shift_next  = tx_data;
            tx_ack_next    = 1'b1;
            first_next     = 1'b1;
            load_pend_next = 1'b0;
        end else if (ss_rise) begin
            frame_err_next = (bit_cnt_reg != '0);
            bit_cnt_next   = '0;
            load_pend_next = 1'b0;
        end else if (!ss_now) begin
            if (sample_edge) begin
                rx_shift_next = {rx_shift_reg[DATA_WIDTH-2:0], mosi_now};
                if (bit_cnt_reg == CNT_W'(DATA_WIDTH-1)) begin
                    bit_cnt_next   = '0;
                    push_next      = 1'b1;
                    push_data_next = {rx_shift_reg[DATA_WIDTH-2:0], mosi_now};
                    load_pend_next = 1'b1;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            if (shift_edge) begin
                if (load_pend_reg) begin
                    // The new MSB is on MISO from this edge on, so the next shift edge must shift.
                    tx_shift_next  = tx_data;
                    tx_ack_next    = 1'b1;
                    first_next     = 1'b0;
                    load_pend_next = 1'b0;
                end else if ((CPHA != 0) && first_reg) begin
                    first_next = 1'b0;
                end else begin
                    tx_shift_next = {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            tx_shift_reg  <= '0;
            push_data_reg <= '0;
            first_reg     <= 1'b0;
            load_pend_reg <= 1'b0;
            push_reg      <= 1'b0;
            tx_ack_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            bit_cnt_reg   <= bit_cnt_next;
            rx_shift_reg  <= rx_shift_next;
            tx_shift_reg  <= tx_shift_next;
            push_data_reg <= push_data_next;
            first_reg     <= first_next;
            load_pend_reg <= load_pend_next;
            push_reg      <= push_next;
            tx_ack_reg    <= tx_ack_next;
            frame_err_reg <= frame_err_next;
        end
    end

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [COUNT_W-1:0]    count_reg;
    logic                  overflow_reg;
    logic                  fifo_full, do_pop, do_push, do_drop;

    assign fifo_full = (count_reg == COUNT_W'(FIFO_DEPTH));
    assign do_pop    = rx_valid & rx_ready;
    assign do_push   = push_reg & (~fifo_full | do_pop);
    assign do_drop   = push_reg & fifo_full & ~do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (do_drop)      overflow_reg <= 1'b1;
            else if (ovf_clr) overflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr_reg] <= push_data_reg;
    end

    assign rx_valid  = (count_reg != '0);
    assign rx_count  = count_reg;
    assign rx_data   = rx_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign overflow  = overflow_reg;
    assign MISO      = tx_shift_reg[DATA_WIDTH-1];
    assign miso_oe   = ~ss_prev;
    assign tx_ack    = tx_ack_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: one instance per CPOL/CPHA mode, a bit-banged SPI master,
// a queue-based reference FIFO and a monitor that checks every popped word.
`timescale 1ns/1ps
module tb_spi_slave_fifo;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int H     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [3:0]   ss_pad, sclk_pad, mosi_pad, rdy_v, ovf_clr_v;
    logic [3:0]   miso_v, oe_v, valid_v, ack_v, ovf_v, ferr_v;
    logic [W-1:0] rx_data_a [4];
    logic [2:0]   rx_count_a [4];
    logic [W-1:0] tx_data;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            spi_slave_fifo #(
                .DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .CPOL(gi / 2), .CPHA(gi % 2)
            ) u_dut (
                .clk(clk), .reset(reset), .SS(ss_pad[gi]), .SCLK(sclk_pad[gi]),
                .MOSI(mosi_pad[gi]), .MISO(miso_v[gi]), .miso_oe(oe_v[gi]),
                .rx_data(rx_data_a[gi]), .rx_valid(valid_v[gi]), .rx_ready(rdy_v[gi]),
                .rx_count(rx_count_a[gi]), .tx_data(tx_data), .tx_ack(ack_v[gi]),
                .overflow(ovf_v[gi]), .ovf_clr(ovf_clr_v[gi]), .frame_err(ferr_v[gi])
            );
        end
    endgenerate

    logic [W-1:0] exp_q [$];
    logic [W-1:0] mosi_words [8];
    logic [W-1:0] miso_words [8];
    logic [W-1:0] mon_exp;
    bit           exp_ovf;
    bit           rdy_rand;
    int           cur_mode;
    int           checks, failures;
    int           ack_cnt, ferr_cnt;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference FIFO: a word is kept if there is room or a pop lands in the same cycle.
    task automatic push_model(input logic [W-1:0] word, input bit coincide_pop);
        if (exp_q.size() < DEPTH || coincide_pop) exp_q.push_back(word);
        else exp_ovf = 1'b1;
    endtask

    task automatic post_sample_wait(input int m, input bit special);
        if (special) begin
            tick(3);
            rdy_v[m] = 1'b1;
            tick(1);
            rdy_v[m] = 1'b0;
            tick(H - 4);
        end else begin
            tick(H);
        end
    endtask

    task automatic spi_frame(input int m, input int nbits, input bit special, input bit keep_ss);
        int           cpha, nw, w, i, exp_ack;
        bit           last, sp;
        logic         idle;
        logic [W-1:0] got;
        cpha = m % 2;
        idle = (m >= 2);
        nw   = nbits / W;
        got  = '0;
        cur_mode = m;
        ack_cnt  = 0;
        ferr_cnt = 0;
        tx_data  = miso_words[0];
        ss_pad[m] = 1'b0;
        tick(H);
        check("miso_oe_active", oe_v[m], 1);
        for (int b = 0; b < nbits; b++) begin
            w    = b / W;
            i    = W - 1 - (b % W);
            last = (b % W == W - 1);
            sp   = last && special && (w == nw - 1);
            if (last) tx_data = miso_words[w + 1];
            if (cpha == 0) begin
                mosi_pad[m] = mosi_words[w][i];
                tick(H);
                got = {got[W-2:0], miso_v[m]};
                sclk_pad[m] = ~idle;
                if (last) push_model(mosi_words[w], sp);
                post_sample_wait(m, sp);
                sclk_pad[m] = idle;
            end else begin
                sclk_pad[m] = ~idle;
                mosi_pad[m] = mosi_words[w][i];
                tick(H);
                got = {got[W-2:0], miso_v[m]};
                sclk_pad[m] = idle;
                if (last) push_model(mosi_words[w], sp);
                post_sample_wait(m, sp);
            end
            if (last) check("miso_word", got, miso_words[w]);
        end
        if (cpha == 0) tick(H);
        if (!keep_ss) begin
            check("miso_oe_frame", oe_v[m], 1);
            ss_pad[m] = 1'b1;
            tick(H);
            check("miso_oe_idle", oe_v[m], 0);
            check("frame_err_pulses", ferr_cnt, (nbits % W) != 0);
            exp_ack = 1 + nw;
            if (cpha == 1 && (nbits % W) == 0) exp_ack--;
            check("tx_ack_pulses", ack_cnt, exp_ack);
        end
        $display("frame mode=%0d bits=%0d mosi0=%h miso0=%h queued=%0d", m, nbits,
                 mosi_words[0], miso_words[0], exp_q.size());
    endtask

    task automatic check_quiet(input int m);
        check("rx_count", rx_count_a[m], exp_q.size());
        check("rx_valid", valid_v[m], exp_q.size() != 0);
        check("overflow", ovf_v[m], exp_ovf);
        if (exp_q.size() != 0) check("rx_head", rx_data_a[m], exp_q[0]);
        else check("rx_data_empty", rx_data_a[m], 0);
    endtask

    task automatic check_reset(input int m);
        check("rst_rx_count", rx_count_a[m], 0);
        check("rst_rx_valid", valid_v[m], 0);
        check("rst_rx_data", rx_data_a[m], 0);
        check("rst_miso", miso_v[m], 0);
        check("rst_miso_oe", oe_v[m], 0);
        check("rst_overflow", ovf_v[m], 0);
        check("rst_tx_ack", ack_v[m], 0);
        check("rst_frame_err", ferr_v[m], 0);
    endtask

    task automatic drain(input int m);
        rdy_rand = 1'b0;
        rdy_v[m] = 1'b1;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick(1);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d words left want 0", exp_q.size());
            exp_q.delete();
        end
        rdy_v[m] = 1'b0;
        tick(1);
        check_quiet(m);
    endtask

    task automatic fill_words(input int n);
        for (int k = 0; k < 8; k++) begin
            mosi_words[k] = (k < n) ? $urandom : '0;
            miso_words[k] = $urandom;
        end
    endtask

    // Monitor: every pop the DUT performs must match the head of the reference queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (ack_v[cur_mode])  ack_cnt++;
            if (ferr_v[cur_mode]) ferr_cnt++;
            if (valid_v[cur_mode] && rdy_v[cur_mode]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_pop: got %h want no word", rx_data_a[cur_mode]);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_pop", rx_data_a[cur_mode], mon_exp);
                    $display("pop mode=%0d data=%h", cur_mode, rx_data_a[cur_mode]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) rdy_v[cur_mode] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int m, nbits, nw;
        reset = 1'b1;
        ss_pad = 4'b1111; sclk_pad = 4'b1100; mosi_pad = '0;
        rdy_v = '0; ovf_clr_v = '0; tx_data = '0;
        cur_mode = 0; rdy_rand = 1'b0; exp_ovf = 1'b0;
        checks = 0; failures = 0; ack_cnt = 0; ferr_cnt = 0;
        tick(4);
        for (int k = 0; k < 4; k++) check_reset(k);
        reset = 1'b0;
        tick(4);

        // Mode 0 basic frame
        fill_words(1);
        mosi_words[0] = 32'hA5A5_0F0F;
        miso_words[0] = 32'h1234_5678;
        spi_frame(0, 32, 1'b0, 1'b0);
        check_quiet(0);
        drain(0);

        // Every CPOL/CPHA mode
        for (int k = 0; k < 4; k++) begin
            fill_words(1);
            mosi_words[0] = 32'hDEAD_BEEF;
            miso_words[0] = 32'hCAFE_F00D;
            spi_frame(k, 32, 1'b0, 1'b0);
            check_quiet(k);
            drain(k);
        end

        // Five words into a four-deep FIFO with no reads
        fill_words(5);
        spi_frame(0, 5 * W, 1'b0, 1'b0);
        check_quiet(0);
        ovf_clr_v[0] = 1'b1;
        tick(1);
        ovf_clr_v[0] = 1'b0;
        exp_ovf = 1'b0;
        tick(1);
        check_quiet(0);
        drain(0);

        // Fifth word lands on a full FIFO in the same cycle as a pop
        fill_words(5);
        spi_frame(0, 5 * W, 1'b1, 1'b0);
        check_quiet(0);
        drain(0);

        // Aborted word, then a clean frame
        fill_words(1);
        spi_frame(0, 13, 1'b0, 1'b0);
        check_quiet(0);
        fill_words(1);
        spi_frame(0, 32, 1'b0, 1'b0);
        check_quiet(0);
        drain(0);

        // Reset in the middle of a frame, released with SS still low
        fill_words(1);
        spi_frame(0, 20, 1'b0, 1'b1);
        reset = 1'b1;
        tick(2);
        check_reset(0);
        exp_q.delete();
        exp_ovf = 1'b0;
        reset = 1'b0;
        tick(H);
        ferr_cnt = 0;
        ss_pad[0] = 1'b1;
        tick(H);
        check("frame_err_after_reset", ferr_cnt, 0);
        fill_words(1);
        spi_frame(0, 32, 1'b0, 1'b0);
        check_quiet(0);
        drain(0);

        // Randomised frames with random read back-pressure
        for (int r = 0; r < 12; r++) begin
            m = $urandom_range(0, 3);
            if (m % 2 == 0) begin
                nw    = $urandom_range(1, 3);
                nbits = nw * W;
                if ($urandom_range(0, 3) == 0) nbits = (nw - 1) * W + $urandom_range(1, W - 1);
            end else begin
                nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : W;
            end
            fill_words((nbits + W - 1) / W);
            cur_mode = m;
            rdy_rand = 1'b1;
            spi_frame(m, nbits, 1'b0, 1'b0);
            drain(m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
